sim_uart_console_mux: RTL



---
 rtl/sim_uart_console_mux.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/sim_uart_console_mux.sv
// rtl/sim_uart_console_mux.sv - per-hart UART line buffers merged line-atomically onto one console port
// Optional partial-line flush after an idle period: define SIM_UART_TIMEOUT_FLUSH_EN.
module sim_uart_console_mux #(
    parameter int NUM_CH        = 2,
    parameter int DEPTH         = 64,
    parameter int FLUSH_TIMEOUT = 1024,
    localparam int SW           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [NUM_CH-1:0]   in_valid,
    input  logic [8*NUM_CH-1:0] in_ch,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [7:0]          out_ch,
    output logic [SW-1:0]       out_src,
    output logic                out_last,
    output logic [NUM_CH-1:0]   ovf_sticky
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    if (DEPTH < 4 || (DEPTH & (DEPTH - 1)) != 0 || NUM_CH < 1 || NUM_CH > 16 || FLUSH_TIMEOUT < 1) begin : g_bad_param
        $error("sim_uart_console_mux: illegal parameter set");
    end

    typedef enum logic [0:0] {IDLE, DRAIN} state_t;

    state_t           state;
    logic [SW-1:0]    sel;
    logic [SW-1:0]    rr_ptr;
    logic [CW-1:0]    budget;

    logic [7:0]       mem     [NUM_CH][DEPTH];
    logic [AW-1:0]    wr_ptr  [NUM_CH];
    logic [AW-1:0]    rd_ptr  [NUM_CH];
    logic [CW-1:0]    count   [NUM_CH];
    logic [CW-1:0]    line_cnt[NUM_CH];

    logic [NUM_CH-1:0] full, push, pop, push_nl, pop_nl, eligible;
    logic             any_eligible;
    logic [SW-1:0]    grant;
    logic [AW-1:0]    rd_next;
    logic [7:0]       next_ch;
    logic [7:0]       grant_ch;

`ifdef SIM_UART_TIMEOUT_FLUSH_EN
    localparam int TW = $clog2(FLUSH_TIMEOUT + 1);
    logic [TW-1:0]    idle_cnt[NUM_CH];
`endif

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            full[i]     = (count[i] == CW'(DEPTH));
            push[i]     = in_valid[i] && !full[i];
            pop[i]      = (state == DRAIN) && out_ready && (sel == SW'(i));
            push_nl[i]  = push[i] && (in_ch[8*i +: 8] == 8'h0A);
            pop_nl[i]   = pop[i] && (mem[i][rd_ptr[i]] == 8'h0A);
`ifdef SIM_UART_TIMEOUT_FLUSH_EN
            eligible[i] = (line_cnt[i] != '0) || full[i] ||
                          ((count[i] != '0) && (idle_cnt[i] == TW'(FLUSH_TIMEOUT)));
`else
            eligible[i] = (line_cnt[i] != '0) || full[i];
`endif
        end
    end

    // Scan downward so the channel closest to rr_ptr is the last (winning) assignment.
    always_comb begin
        any_eligible = 1'b0;
        grant        = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            int idx;
            idx = int'(rr_ptr) + k;
            if (idx >= NUM_CH) idx = idx - NUM_CH;
            if (eligible[idx]) begin
                any_eligible = 1'b1;
                grant        = SW'(idx);
            end
        end
    end

    assign rd_next  = rd_ptr[sel] + 1'b1;
    assign next_ch  = mem[sel][rd_next];
    assign grant_ch = mem[grant][rd_ptr[grant]];

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (push[i]) mem[i][wr_ptr[i]] <= in_ch[8*i +: 8];
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!reset) begin
                wr_ptr[i]     <= '0;
                rd_ptr[i]     <= '0;
                count[i]      <= '0;
                line_cnt[i]   <= '0;
                ovf_sticky[i] <= 1'b0;
            end else begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + 1'b1;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + 1'b1;
                if (push[i] && !pop[i])      count[i] <= count[i] + 1'b1;
                else if (!push[i] && pop[i]) count[i] <= count[i] - 1'b1;
                if (push_nl[i] && !pop_nl[i])      line_cnt[i] <= line_cnt[i] + 1'b1;
                else if (!push_nl[i] && pop_nl[i]) line_cnt[i] <= line_cnt[i] - 1'b1;
                if (in_valid[i] && full[i]) ovf_sticky[i] <= 1'b1;
            end
        end
    end

`ifdef SIM_UART_TIMEOUT_FLUSH_EN
    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (!reset || push[i])                      idle_cnt[i] <= '0;
            else if (idle_cnt[i] != TW'(FLUSH_TIMEOUT)) idle_cnt[i] <= idle_cnt[i] + 1'b1;
        end
    end
`endif

    // Budget caps the line at the grant-time count, so next_ch is always already stored.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state     <= IDLE;
            sel       <= '0;
            rr_ptr    <= '0;
            budget    <= '0;
            out_valid <= 1'b0;
            out_ch    <= '0;
            out_src   <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (any_eligible) begin
                        state     <= DRAIN;
                        sel       <= grant;
                        budget    <= count[grant];
                        out_valid <= 1'b1;
                        out_ch    <= grant_ch;
                        out_src   <= grant;
                        out_last  <= (grant_ch == 8'h0A) || (count[grant] == CW'(1));
                    end
                end
                DRAIN: begin
                    if (out_ready) begin
                        if (out_last) begin
                            state     <= IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            rr_ptr    <= (sel == SW'(NUM_CH - 1)) ? '0 : sel + 1'b1;
                        end else begin
                            budget   <= budget - 1'b1;
                            out_ch   <= next_ch;
                            out_last <= (next_ch == 8'h0A) || (budget == CW'(2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
